contador_sequencia_param: RTL and testbench

//  Parametrised table-driven sequence counter: steps through LEN codes of width W held in an internal table.

---
 rtl/contador_sequencia_pkg.sv | 33 +++
 rtl/contador_sequencia_param_seq_table.sv | 33 +++
 rtl/contador_sequencia_param.sv | 125 ++++++++++++
 tb/tb_contador_sequencia_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/contador_sequencia_pkg.sv
// Shared types and helpers for the table-driven sequence counter.
// Pure declarations: no latency, no flow control.
package contador_sequencia_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // Upper bounds for the generic entry extractor below.
    localparam int SEQ_MAX_BITS = 1024;
    localparam int SEQ_MAX_W    = 32;

    // Default table: 0,1,2,3,10,13 followed by two unused zero entries.
    localparam logic [31:0] SEQ_DEFAULT = 32'h00DA_3210;

    // Extract entry i (w bits wide) from a packed table, entry i at bits [i*w +: w].
    function automatic logic [SEQ_MAX_W-1:0] seq_entry(
        input logic [SEQ_MAX_BITS-1:0] seq,
        input int                      i,
        input int                      w
    );
        logic [SEQ_MAX_W-1:0] r;
        r = '0;
        for (int b = 0; b < SEQ_MAX_W; b++) begin
            if (b < w && (i * w + b) < SEQ_MAX_BITS) begin
                r[b] = seq[i * w + b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_sequencia_param_seq_table.sv
// DEPTH x W register file, async reset to INIT_SEQ, one write port, one async read port.
// Write lands on the clock edge; read is combinational. No backpressure.
module seq_table
    import contador_sequencia_pkg::*;
#(
    parameter int                 W        = 4,
    parameter int                 DEPTH    = 8,
    parameter logic [DEPTH*W-1:0] INIT_SEQ = (DEPTH*W)'(SEQ_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= W'(seq_entry(SEQ_MAX_BITS'(INIT_SEQ), i, W));
            end
        end else if (wr_en && int'(wr_addr) < DEPTH) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/contador_sequencia_param.sv
// Table-driven sequence counter with enable, up/down, index load and wrap pulse.
// Outputs follow 1 clk after the qualifying edge; free-running, no backpressure. Runtime table/length programming under SEQ_PROG_EN.
module contador_sequencia_param
    import contador_sequencia_pkg::*;
#(
    parameter int                 W        = 4,
    parameter int                 DEPTH    = 8,
    parameter int                 LEN      = 6,
    parameter logic [DEPTH*W-1:0] INIT_SEQ = (DEPTH*W)'(SEQ_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     load,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
`ifdef SEQ_PROG_EN
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic                     len_we,
    input  logic [$clog2(DEPTH):0]   len_in,
`endif
    output logic [W-1:0]             y,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     wrap
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;

    logic [IW-1:0] idx_q, idx_d;
    logic          wrap_q, wrap_d;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_last;
    logic          len_wr;
    logic          at_end, at_start, load_ok;

    logic          tbl_wr_en;
    logic [IW-1:0] tbl_wr_addr;
    logic [W-1:0]  tbl_wr_data;

`ifdef SEQ_PROG_EN
    // Out-of-range lengths are dropped so idx can never point past the table.
    assign len_wr = len_we && (len_in != '0) && (int'(len_in) <= DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= LW'(LEN);
        end else if (len_wr) begin
            len_q <= len_in;
        end
    end

    assign tbl_wr_en   = wr_en;
    assign tbl_wr_addr = wr_addr;
    assign tbl_wr_data = wr_data;
`else
    assign len_wr      = 1'b0;
    assign len_q       = LW'(LEN);
    assign tbl_wr_en   = 1'b0;
    assign tbl_wr_addr = '0;
    assign tbl_wr_data = '0;
`endif

    assign len_last = len_q - LW'(1);
    assign at_end   = ({1'b0, idx_q} == len_last);
    assign at_start = (idx_q == '0);
    assign load_ok  = ({1'b0, load_idx} < len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    // Priority: length write, then load, then enable step.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (len_wr) begin
            idx_d = '0;
        end else if (load) begin
            idx_d = load_ok ? load_idx : '0;
        end else if (en) begin
            if (dir_t'(dir) == UP) begin
                if (at_end) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                if (at_start) begin
                    idx_d  = len_last[IW-1:0];
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
        end
    end

    seq_table #(
        .W        (W),
        .DEPTH    (DEPTH),
        .INIT_SEQ (INIT_SEQ)
    ) u_seq_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tbl_wr_en),
        .wr_addr (tbl_wr_addr),
        .wr_data (tbl_wr_data),
        .rd_addr (idx_q),
        .rd_data (y)
    );

    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_contador_sequencia_param.sv
// Bench for contador_sequencia_param: directed scenarios plus randomized traffic against a behavioural model.
module tb_contador_sequencia_param;

    localparam int W     = 4;
    localparam int DEPTH = 8;
    localparam int LEN   = 6;
    localparam int IW    = 3;
    localparam int LW    = 4;

    localparam int INIT_TBL [DEPTH] = '{0, 1, 2, 3, 10, 13, 0, 0};
    localparam int EXP_UP   [13]    = '{1, 2, 3, 10, 13, 0, 1, 2, 3, 10, 13, 0, 1};
    localparam int EXP_DN   [7]     = '{13, 10, 3, 2, 1, 0, 13};

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          en       = 1'b0;
    logic          dir      = 1'b0;
    logic          load     = 1'b0;
    logic [IW-1:0] load_idx = '0;
    logic [W-1:0]  y;
    logic [IW-1:0] idx;
    logic          wrap;
`ifdef SEQ_PROG_EN
    logic          wr_en    = 1'b0;
    logic [IW-1:0] wr_addr  = '0;
    logic [W-1:0]  wr_data  = '0;
    logic          len_we   = 1'b0;
    logic [LW-1:0] len_in   = '0;
`endif

    contador_sequencia_param #(
        .W     (W),
        .DEPTH (DEPTH),
        .LEN   (LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_idx (load_idx),
`ifdef SEQ_PROG_EN
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .len_we   (len_we),
        .len_in   (len_in),
`endif
        .y        (y),
        .idx      (idx),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_tbl [DEPTH];
    int m_len;
    int m_idx;
    bit m_wrap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = INIT_TBL[i];
        m_len  = LEN;
        m_idx  = 0;
        m_wrap = 1'b0;
    endtask

    // Next state from the sequence rules: modular stepping over the active length.
    task automatic model_edge();
        bit len_ok;
        len_ok = 1'b0;
`ifdef SEQ_PROG_EN
        len_ok = len_we && (len_in >= 1) && (len_in <= DEPTH);
        if (wr_en && wr_addr < DEPTH) m_tbl[wr_addr] = wr_data;
`endif
        m_wrap = 1'b0;
        if (len_ok) begin
`ifdef SEQ_PROG_EN
            m_len = len_in;
`endif
            m_idx = 0;
        end else if (load) begin
            m_idx = (load_idx < m_len) ? int'(load_idx) : 0;
        end else if (en) begin
            if (!dir) begin
                m_wrap = (m_idx + 1 >= m_len);
                m_idx  = (m_idx + 1) % m_len;
            end else begin
                m_wrap = (m_idx == 0);
                m_idx  = (m_idx + m_len - 1) % m_len;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_y"},    y,    m_tbl[m_idx]);
        chk({tag, "_idx"},  idx,  m_idx);
        chk({tag, "_wrap"}, wrap, m_wrap);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        #2;
        check_outputs("rst");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");

        // Free-running up count across two wraps
        reset = 1'b1;
        en    = 1'b1;
        dir   = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step("up");
            chk("up_seq_y", y, EXP_UP[i]);
            chk("up_seq_wrap", wrap, (EXP_UP[i] == 0));
        end

        // Down count from index 0
        load     = 1'b1;
        load_idx = '0;
        step("ld0");
        load = 1'b0;
        dir  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step("dn");
            chk("dn_seq_y", y, EXP_DN[i]);
            chk("dn_seq_wrap", wrap, (i == 0 || i == 6));
        end

        // Load beats enable; out-of-range load goes to 0
        dir      = 1'b0;
        load     = 1'b1;
        load_idx = 3'd4;
        step("ld4");
        chk("ld4_y", y, 10);
        load_idx = 3'd7;
        step("ld7");
        chk("ld7_y", y, 0);

        // Async reset between edges, mid-sequence
        load_idx = 3'd4;
        step("ld4b");
        load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_y", y, 0);
        chk("arst_idx", idx, 0);
        chk("arst_wrap", wrap, 0);
        #2;
        reset = 1'b1;
        step("post_rst");
        chk("post_rst_y", y, 1);

`ifdef SEQ_PROG_EN
        len_we = 1'b1;
        len_in = 4'd3;
        step("len3");
        len_we = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step("len3_run");
            chk("len3_y", y, (i + 1) % 3);
            chk("len3_wrap", wrap, ((i + 1) % 3 == 0));
        end
        len_we = 1'b1;
        len_in = 4'd0;
        step("len0");
        chk("len0_ignored_y", y, 2);
        len_in = 4'd6;
        step("len6");
        len_we = 1'b0;
        step("to_idx1");
        en      = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 4'hF;
        step("wr_cur");
        chk("wr_cur_y", y, 15);
        wr_en = 1'b0;
        en    = 1'b1;
        step("wr_next");
        chk("wr_next_y", y, 2);
        step("wr_next2");
        chk("wr_next2_y", y, 3);
`endif

        // Randomized traffic, with occasional async resets
        for (int c = 0; c < 600; c++) begin
            en       = ($urandom_range(0, 3) != 0);
            dir      = $urandom_range(0, 1);
            load     = ($urandom_range(0, 9) == 0);
            load_idx = IW'($urandom_range(0, DEPTH - 1));
`ifdef SEQ_PROG_EN
            wr_en    = ($urandom_range(0, 5) == 0);
            wr_addr  = IW'($urandom_range(0, DEPTH - 1));
            wr_data  = W'($urandom_range(0, 15));
            len_we   = ($urandom_range(0, 11) == 0);
            len_in   = LW'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                check_outputs("rnd_arst");
                #1;
                reset = 1'b1;
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
